// File: rtl/cpu_seq_pkg.sv
`default_nettype none
//============================================================================
// Module   : cpu_seq_pkg
// Purpose  : Shared types and constants for the multi-cycle CPU sequencer.
//            Holds the sequencer state enum, the default PC width and
//            memory latency, the cycle-counter width and the MEM dwell
//            timer width.
// Ports    : none (package)
// Revision : 1.0 - initial release
//============================================================================
package cpu_seq_pkg;

   localparam int c_PC_W_DEFAULT    = 10;
   localparam int c_MEM_LAT_DEFAULT = 1;
   localparam int c_CYCLE_CNT_W     = 16;
   // MEM_LAT is limited to 1..15, so four bits cover the dwell counter.
   localparam int c_WAIT_W          = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALTED = 3'd6
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_seq_wait_timer.sv
`default_nettype none
//============================================================================
// Module   : cpu_seq_wait_timer
// Purpose  : Loadable down-counter that times the dwell in the MEM state.
//            A load pulse arms it with the latency; o_expire is high in the
//            last dwell cycle (and whenever the counter is idle at zero).
// Ports    : clk      - clock
//            rst      - asynchronous active-high reset, clears the counter
//            i_load   - arm pulse, issued on the cycle before MEM is entered
//            i_lat    - dwell length in cycles (1..15)
//            o_expire - current cycle is the final dwell cycle
// Revision : 1.0 - initial release
//============================================================================
module cpu_seq_wait_timer
   import cpu_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [c_WAIT_W-1:0] i_lat,
   output logic                o_expire
);

   localparam logic [c_WAIT_W-1:0] c_ONE = {{(c_WAIT_W-1){1'b0}}, 1'b1};

   logic [c_WAIT_W-1:0] r_count;

   // Loading lat-1 makes the counter reach zero in the lat-th cycle after
   // the load, so expire marks the last dwell cycle. A latency of zero is
   // treated as one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= (i_lat == '0) ? '0 : (i_lat - c_ONE);
      end else if (r_count != '0) begin
         r_count <= r_count - c_ONE;
      end
   end

   assign o_expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
//============================================================================
// Module   : cpu_sequencer
// Purpose  : Multi-cycle sequencer for the 9-bit-instruction CPU. Owns the
//            program counter and the FETCH/DECODE/EXEC/MEM/WB state machine
//            and turns the decoder flags into state-qualified, single-cycle
//            enables. All outputs are Moore outputs.
// Option   : CPU_SEQ_CYCLE_COUNT_EN - adds the saturating cycle_count output.
// Ports    : Clk, Reset        - clock, asynchronous active-high reset
//            Start             - level, (re)start at PC 0 from IDLE/HALTED
//            dec_*             - decoder flags, latched in DECODE
//            br_taken/target   - branch outcome, sampled in EXEC only
//            pc                - current instruction address
//            ir_we/rf_we/dm_we - IR, register-file, data-memory enables
//            done              - program halted
//            cycle_count       - active cycles of the current run (option)
// Revision : 1.0 - initial release
//============================================================================
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int PC_W    = c_PC_W_DEFAULT,
   parameter int MEM_LAT = c_MEM_LAT_DEFAULT
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic                     dec_branch,
   input  logic                     dec_mem_to_reg,
   input  logic                     dec_mem_write,
   input  logic                     dec_reg_write,
   input  logic                     dec_halt,
   input  logic                     br_taken,
   input  logic [PC_W-1:0]          br_target,
   output logic [PC_W-1:0]          pc,
   output logic                     ir_we,
   output logic                     rf_we,
   output logic                     dm_we,
`ifdef CPU_SEQ_CYCLE_COUNT_EN
   output logic [c_CYCLE_CNT_W-1:0] cycle_count,
`endif
   output logic                     done
);

   localparam logic [PC_W-1:0]     c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [c_WAIT_W-1:0] c_LAT    = c_WAIT_W'(MEM_LAT);

   seq_state_t      r_state;
   seq_state_t      w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nxt;
   logic            r_branch;
   logic            r_load;
   logic            r_store;
   logic            r_reg_write;
   logic            r_mem_first;
   logic            w_halt;
   logic            w_timer_load;
   logic            w_expire;

   // An unknown Halt flag must not stop the machine: only a solid 1 counts.
   assign w_halt = (dec_halt === 1'b1);

   cpu_seq_wait_timer u_wait_timer (
      .clk      (Clk),
      .rst      (Reset),
      .i_load   (w_timer_load),
      .i_lat    (c_LAT),
      .o_expire (w_expire)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_pc        <= '0;
         r_mem_first <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         // The timer is armed exactly on the EXEC->MEM transition, so this
         // flags the first MEM cycle for the one-shot store enable.
         r_mem_first <= w_timer_load;
      end
   end

   // Decoder flags are captured once per instruction and held until the
   // next DECODE, so the decoder may change freely afterwards.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_branch    <= 1'b0;
         r_load      <= 1'b0;
         r_store     <= 1'b0;
         r_reg_write <= 1'b0;
      end else if (r_state == DECODE) begin
         r_branch    <= dec_branch;
         r_load      <= dec_mem_to_reg;
         r_store     <= dec_mem_write;
         r_reg_write <= dec_reg_write;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_timer_load = 1'b0;
      ir_we        = 1'b0;
      rf_we        = 1'b0;
      dm_we        = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (Start) begin
               w_pc_nxt    = '0;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            ir_we       = 1'b1;
            w_state_nxt = DECODE;
         end
         DECODE: begin
            w_state_nxt = w_halt ? HALTED : EXEC;
         end
         EXEC: begin
            if (r_branch) begin
               w_pc_nxt    = br_taken ? br_target : (r_pc + c_PC_ONE);
               w_state_nxt = FETCH;
            end else if (r_load || r_store) begin
               w_timer_load = 1'b1;
               w_state_nxt  = MEM;
            end else begin
               w_state_nxt = WB;
            end
         end
         MEM: begin
            dm_we = r_mem_first & r_store;
            if (w_expire) begin
               // Load+store behaves as a store: no write-back.
               if (r_store) begin
                  w_pc_nxt    = r_pc + c_PC_ONE;
                  w_state_nxt = FETCH;
               end else begin
                  w_state_nxt = WB;
               end
            end
         end
         WB: begin
            rf_we       = r_reg_write;
            w_pc_nxt    = r_pc + c_PC_ONE;
            w_state_nxt = FETCH;
         end
         HALTED: begin
            done = 1'b1;
            if (Start) begin
               w_pc_nxt    = '0;
               w_state_nxt = FETCH;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign pc = r_pc;

`ifdef CPU_SEQ_CYCLE_COUNT_EN
   localparam logic [c_CYCLE_CNT_W-1:0] c_CNT_ONE = {{(c_CYCLE_CNT_W-1){1'b0}}, 1'b1};

   logic [c_CYCLE_CNT_W-1:0] r_cycle_cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cycle_cnt <= '0;
      end else if ((r_state == IDLE) || (r_state == HALTED)) begin
         if (Start) begin
            r_cycle_cnt <= '0;
         end
      end else if (r_cycle_cnt != '1) begin
         r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
      end
   end

   assign cycle_count = r_cycle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
//============================================================================
// Module   : tb_cpu_sequencer
// Purpose  : Self-checking bench for cpu_sequencer. The bench plays the
//            instruction memory and decoder; a per-instruction model built
//            from the latency rules pushes one expected output vector per
//            cycle into a queue, and a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
//============================================================================
module tb_cpu_sequencer;

   localparam int PW     = 10;
   localparam int LAT    = 3;
   localparam int DEPTH  = 1 << PW;
   localparam int K_ALU  = 0;
   localparam int K_BR   = 1;
   localparam int K_LD   = 2;
   localparam int K_ST   = 3;
   localparam int K_LDST = 4;
   localparam int K_HALT = 5;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic          dec_branch, dec_mem_to_reg, dec_mem_write, dec_reg_write, dec_halt;
   logic          br_taken;
   logic [PW-1:0] br_target;
   logic [PW-1:0] pc;
   logic          ir_we, rf_we, dm_we, done;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
   logic [15:0]   cycle_count;
`endif

   cpu_sequencer #(.PC_W(PW), .MEM_LAT(LAT)) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Start          (Start),
      .dec_branch     (dec_branch),
      .dec_mem_to_reg (dec_mem_to_reg),
      .dec_mem_write  (dec_mem_write),
      .dec_reg_write  (dec_reg_write),
      .dec_halt       (dec_halt),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .pc             (pc),
      .ir_we          (ir_we),
      .rf_we          (rf_we),
      .dm_we          (dm_we),
`ifdef CPU_SEQ_CYCLE_COUNT_EN
      .cycle_count    (cycle_count),
`endif
      .done           (done)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic          ir;
      logic          rf;
      logic          dm;
      logic          dn;
      logic [PW-1:0] pc;
      logic [15:0]   cc;
   } vec_t;

   vec_t          exp_q[$];
   int            n_assert = 0;
   int            n_fail   = 0;
   bit            run_on   = 1'b0;
   // program image
   int            m_kind[DEPTH];
   bit            m_rw[DEPTH];
   bit            m_tk[DEPTH];
   logic [PW-1:0] m_tgt[DEPTH];
   // reference-model state
   logic [PW-1:0] m_pc;
   bit            m_halted;
   logic [15:0]   cc_m;
   // instruction-register tracking for the decoder stand-in
   int            ir_addr;
   int            phase;

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @%0t: actual %h required %h", name, $time, act, req);
      end
   endtask

   function automatic vec_t mk(bit ir, bit rf, bit dm, bit dn, logic [PW-1:0] p);
      vec_t v;
      v.ir = ir; v.rf = rf; v.dm = dm; v.dn = dn; v.pc = p;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
      v.cc = cc_m;
`else
      v.cc = '0;
`endif
      return v;
   endfunction

   function automatic vec_t act_vec();
      vec_t v;
      v.ir = ir_we; v.rf = rf_we; v.dm = dm_we; v.dn = done; v.pc = pc;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
      v.cc = cycle_count;
`else
      v.cc = '0;
`endif
      return v;
   endfunction

   // One running cycle: the counter advances (saturating) after it.
   task automatic push_active(bit ir, bit rf, bit dm, logic [PW-1:0] p);
      exp_q.push_back(mk(ir, rf, dm, 1'b0, p));
      if (cc_m != 16'hFFFF) cc_m++;
   endtask

   task automatic push_quiet(bit dn, logic [PW-1:0] p);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, dn, p));
   endtask

   task automatic set_i(int a, int k, bit rw, bit tk, int tgt);
      m_kind[a] = k; m_rw[a] = rw; m_tk[a] = tk; m_tgt[a] = PW'(tgt);
   endtask

   task automatic fill_random();
      int r;
      for (int a = 0; a < DEPTH; a++) begin
         r = $urandom_range(0, 15);
         set_i(a, (r == 0) ? K_HALT : (r < 6) ? K_ALU : (r < 9) ? K_BR :
                  (r < 11) ? K_LD : (r < 13) ? K_ST : (r < 14) ? K_LDST : K_ALU,
               1'($urandom), 1'($urandom), $urandom_range(0, DEPTH - 1));
      end
   endtask

   // Expected trace of one instruction from the latency table.
   task automatic model_instr(output int len);
      int a;
      int k;
      bit st;
      bit ld;
      a  = int'(m_pc);
      k  = m_kind[a];
      st = (k == K_ST) || (k == K_LDST);
      ld = (k == K_LD);
      push_active(1'b1, 1'b0, 1'b0, m_pc);
      push_active(1'b0, 1'b0, 1'b0, m_pc);
      len = 2;
      if (k == K_HALT) begin
         m_halted = 1'b1;
         return;
      end
      push_active(1'b0, 1'b0, 1'b0, m_pc);
      len = 3;
      if (k == K_BR) begin
         m_pc = m_tk[a] ? m_tgt[a] : m_pc + PW'(1);
      end else if (ld || st) begin
         for (int i = 0; i < LAT; i++) begin
            push_active(1'b0, 1'b0, (i == 0) && st, m_pc);
            len++;
         end
         if (ld) begin
            push_active(1'b0, m_rw[a], 1'b0, m_pc);
            len++;
         end
         m_pc = m_pc + PW'(1);
      end else begin
         push_active(1'b0, m_rw[a], 1'b0, m_pc);
         len++;
         m_pc = m_pc + PW'(1);
      end
   endtask

   task automatic drive_dec(int a);
      dec_branch     = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_mem_write  = 1'b0;
      dec_reg_write  = m_rw[a];
      case (m_kind[a])
         K_BR:   dec_branch = 1'b1;
         K_LD:   dec_mem_to_reg = 1'b1;
         K_ST:   dec_mem_write = 1'b1;
         K_LDST: begin dec_mem_to_reg = 1'b1; dec_mem_write = 1'b1; end
         K_HALT: begin
            // halt must win over whatever else the decoder reports
            {dec_branch, dec_mem_to_reg, dec_mem_write, dec_reg_write} = 4'($urandom);
         end
         default: ;
      endcase
      dec_halt = (m_kind[a] == K_HALT);
   endtask

   // Advance one cycle; decoder and branch inputs carry noise except in the
   // cycle where the sequencer is meant to sample them.
   task automatic step();
      @(posedge Clk);
      #1;
      if (ir_we) begin
         ir_addr = int'(pc);
         phase   = 0;
      end else if (phase < 100) begin
         phase++;
      end
      {dec_branch, dec_mem_to_reg, dec_mem_write, dec_reg_write, dec_halt} = 5'($urandom);
      br_taken  = 1'($urandom);
      br_target = PW'($urandom);
      if (phase == 1) drive_dec(ir_addr);
      if (phase == 2) begin
         br_taken  = m_tk[ir_addr];
         br_target = m_tgt[ir_addr];
      end
   endtask

   task automatic start_run();
      step();
      push_quiet(m_halted, m_pc);
      Start    = 1'b1;
      run_on   = 1'b1;
      m_pc     = '0;
      m_halted = 1'b0;
      cc_m     = '0;
   endtask

   task automatic exec_instr();
      int len;
      model_instr(len);
      repeat (len) begin
         step();
         Start = 1'b0;
      end
   endtask

   task automatic hold_halted(int h);
      repeat (h) begin
         step();
         push_quiet(1'b1, m_pc);
      end
   endtask

   task automatic abort_reset(bit with_step);
      if (with_step) step();
      run_on = 1'b0;
      exp_q.delete();
      Reset = 1'b1;
      #1;
      cc_m = '0;
      check("async_reset", act_vec(), mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
      @(posedge Clk);
      #1;
      Reset    = 1'b0;
      m_pc     = '0;
      m_halted = 1'b0;
      phase    = 100;
   endtask

   task automatic run(int kmax);
      start_run();
      for (int n = 0; n < kmax && !m_halted; n++) exec_instr();
      if (m_halted) hold_halted($urandom_range(0, 3));
      else abort_reset(1'b1);
   endtask

   // Monitor: one expected vector per running cycle.
   initial begin
      vec_t e;
      forever begin
         @(negedge Clk);
         if (run_on) begin
            if (exp_q.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL sb_underflow @%0t: actual %h required no cycle", $time, act_vec());
            end else begin
               e = exp_q.pop_front();
               check("sb_cycle", act_vec(), e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0;
      dec_branch = 1'b0; dec_mem_to_reg = 1'b0; dec_mem_write = 1'b0;
      dec_reg_write = 1'b0; dec_halt = 1'b0;
      br_taken = 1'b0; br_target = '0;
      ir_addr = 0; phase = 100;
      m_pc = '0; m_halted = 1'b0; cc_m = '0;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_state", act_vec(), mk(1'b0, 1'b0, 1'b0, 1'b0, '0));
      Reset = 1'b0;

      // Directed program: adds, branches, store/load, wrap-free halt at 1023.
      for (int a = 0; a < DEPTH; a++) set_i(a, K_ALU, 1'b1, 1'b0, 0);
      set_i(4,    K_ALU,  1'b0, 1'b0, 0);
      set_i(5,    K_BR,   1'b1, 1'b0, 2);
      set_i(6,    K_BR,   1'b0, 1'b1, 1022);
      set_i(1022, K_BR,   1'b0, 1'b1, 7);
      set_i(7,    K_ST,   1'b1, 1'b0, 0);
      set_i(8,    K_LD,   1'b1, 1'b0, 0);
      set_i(9,    K_LDST, 1'b1, 1'b0, 0);
      set_i(10,   K_BR,   1'b0, 1'b1, 1023);
      set_i(1023, K_HALT, 1'b0, 1'b0, 0);
      run(50);

      // add, add, halt (ten running cycles).
      set_i(0, K_ALU,  1'b1, 1'b0, 0);
      set_i(1, K_ALU,  1'b1, 1'b0, 0);
      set_i(2, K_HALT, 1'b0, 1'b0, 0);
      run(10);

      // Add at 1023 wraps to 0.
      set_i(0,    K_BR,  1'b0, 1'b1, 1023);
      set_i(1023, K_ALU, 1'b1, 1'b0, 0);
      run(5);

      // Branch to its own address loops.
      set_i(0, K_BR, 1'b0, 1'b1, 0);
      run(3);

      // Reset during the write-back of a load.
      set_i(0, K_LD, 1'b1, 1'b0, 0);
      start_run();
      exec_instr();
      check("ld_wb_rf_we", rf_we, 1);
      abort_reset(1'b0);

      repeat (12) begin
         fill_random();
         run(30);
      end

      @(negedge Clk);
      #1;
      run_on = 1'b0;
      check("sb_drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
